sm4_key_sched: RTL and testbench

SM4 key-schedule controller. Accepts a 128-bit master key, runs the 32-round key expansion at one round per cycle, and sequences the CK constant table with the round counter. Streams each round key out as it is produced and holds all 32 in an internal register file. The encrypt/decrypt round datapath reads that file in forward or reverse order.

---
 rtl/sm4_pkg.sv | 29 ++
 rtl/sm4_ck.sv | 13 +
 rtl/sm4_tprime.sv | 15 +
 rtl/sm4_key_sched.sv | 107 ++++++++++
 tb/tb_sm4_key_sched.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sm4_pkg.sv
// rtl/sm4_pkg.sv - shared SM4 constants, FSM state type and byte S-box
package sm4_pkg;

  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  localparam int SM4_ROUNDS = 32;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Entry 0 sits in the top byte so the table reads in the usual row order.
  localparam logic [2047:0] SM4_SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sm4_sbox(input logic [7:0] i_x);
    return SM4_SBOX[{~i_x, 3'b111} -: 8];
  endfunction

endpackage

// File: rtl/sm4_ck.sv
// rtl/sm4_ck.sv - SM4 CK constant for a round index; byte j = 7*(4i+j) mod 256
module sm4_ck (
  input  logic [4:0]  i_cnt,
  output logic [31:0] o_ck
);

  logic [7:0] w_base;

  assign w_base = {1'b0, i_cnt, 2'b00};
  assign o_ck   = {w_base * 8'd7, (w_base + 8'd1) * 8'd7,
                   (w_base + 8'd2) * 8'd7, (w_base + 8'd3) * 8'd7};

endmodule

// File: rtl/sm4_tprime.sv
// rtl/sm4_tprime.sv - key-schedule T': byte-wise S-box followed by L' (rotates 13 and 23)
module sm4_tprime
  import sm4_pkg::*;
(
  input  logic [31:0] i_x,
  output logic [31:0] o_y
);

  logic [31:0] w_b;

  assign w_b = {sm4_sbox(i_x[31:24]), sm4_sbox(i_x[23:16]),
                sm4_sbox(i_x[15:8]),  sm4_sbox(i_x[7:0])};
  assign o_y = w_b ^ {w_b[18:0], w_b[31:19]} ^ {w_b[8:0], w_b[31:9]};

endmodule

// File: rtl/sm4_key_sched.sv
// rtl/sm4_key_sched.sv - SM4 key expansion, one round per cycle, with a 32-entry round-key file
module sm4_key_sched
  import sm4_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  output logic         rk_valid,
  output logic [31:0]  rk_out,
  output logic [4:0]   rk_idx,
  output logic         done,
  output logic         keys_ok,
  input  logic [4:0]   rd_idx,
  input  logic         rd_dec,
  output logic [31:0]  rk_rd
);

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_k0, r_k1, r_k2, r_k3;
  logic [31:0] r_file [SM4_ROUNDS];
  logic        r_rk_valid, r_done, r_keys_ok;
  logic [31:0] r_rk_out, r_rk_rd;
  logic [4:0]  r_rk_idx;

  logic        w_accept;
  logic [31:0] w_ck, w_t, w_tp, w_rk;
  logic [4:0]  w_rd_sel;

  sm4_ck u_ck (
    .i_cnt (r_cnt),
    .o_ck  (w_ck)
  );

  sm4_tprime u_tprime (
    .i_x (w_t),
    .o_y (w_tp)
  );

  assign key_ready = (r_state == IDLE);
  assign w_accept  = key_valid & key_ready;
  assign w_t       = r_k1 ^ r_k2 ^ r_k3 ^ w_ck;
  assign w_rk      = r_k0 ^ w_tp;
  assign w_rd_sel  = rd_dec ? (5'd31 - rd_idx) : rd_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 5'd0;
      r_rk_valid <= 1'b0;
      r_rk_out   <= 32'd0;
      r_rk_idx   <= 5'd0;
      r_done     <= 1'b0;
      r_keys_ok  <= 1'b0;
      r_rk_rd    <= 32'd0;
    end else begin
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
      r_rk_rd    <= r_file[w_rd_sel];
      if (r_state == IDLE) begin
        if (w_accept) begin
          r_state   <= RUN;
          r_cnt     <= 5'd0;
          r_keys_ok <= 1'b0;
        end
      end else begin
        r_rk_valid <= 1'b1;
        r_rk_out   <= w_rk;
        r_rk_idx   <= r_cnt;
        r_cnt      <= r_cnt + 5'd1;
        if (r_cnt == 5'd31) begin
          r_state   <= IDLE;
          r_done    <= 1'b1;
          r_keys_ok <= 1'b1;
        end
      end
    end
  end

  // Window and file carry no reset: keys_ok gates whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_k0 <= key[127:96] ^ FK0;
      r_k1 <= key[95:64]  ^ FK1;
      r_k2 <= key[63:32]  ^ FK2;
      r_k3 <= key[31:0]   ^ FK3;
    end else if (r_state == RUN) begin
      r_k0 <= r_k1;
      r_k1 <= r_k2;
      r_k2 <= r_k3;
      r_k3 <= w_rk;
    end
    if (r_state == RUN) begin
      r_file[r_cnt] <= w_rk;
    end
  end

  assign rk_valid = r_rk_valid;
  assign rk_out   = r_rk_out;
  assign rk_idx   = r_rk_idx;
  assign done     = r_done;
  assign keys_ok  = r_keys_ok;
  assign rk_rd    = r_rk_rd;

endmodule

// File: tb/tb_sm4_key_sched.sv
// tb/tb_sm4_key_sched.sv - self-checking bench for sm4_key_sched against a software SM4 key schedule
module tb_sm4_key_sched;

  localparam logic [2047:0] TB_SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };
  localparam logic [127:0] STD_MK = 128'h0123456789ABCDEFFEDCBA9876543210;

  logic         clk = 1'b0;
  logic         rst, key_valid, key_ready, rk_valid, done, keys_ok, rd_dec;
  logic [127:0] key;
  logic [31:0]  rk_out, rk_rd;
  logic [4:0]   rk_idx, rd_idx;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_rk [32];
  logic [31:0] obs_rk [32];

  sm4_key_sched dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key       (key),
    .rk_valid  (rk_valid),
    .rk_out    (rk_out),
    .rk_idx    (rk_idx),
    .done      (done),
    .keys_ok   (keys_ok),
    .rd_idx    (rd_idx),
    .rd_dec    (rd_dec),
    .rk_rd     (rk_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_sbox(input int x);
    return TB_SBOX[2047 - 8*x -: 8];
  endfunction

  task automatic model(input logic [127:0] mk);
    logic [31:0] fk [4];
    logic [31:0] k [36];
    logic [31:0] ck, t, b;
    fk = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
    for (int j = 0; j < 4; j++) k[j] = mk[127-32*j -: 32] ^ fk[j];
    for (int i = 0; i < 32; i++) begin
      ck = 32'd0;
      for (int j = 0; j < 4; j++) ck = {ck[23:0], 8'((7 * (4*i + j)) % 256)};
      t = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck;
      for (int j = 0; j < 4; j++) b[8*j +: 8] = ref_sbox(int'(t[8*j +: 8]));
      k[i+4] = k[i] ^ b ^ ((b << 13) | (b >> 19)) ^ ((b << 23) | (b >> 9));
      exp_rk[i] = k[i+4];
    end
  endtask

  // Caller has already presented key_valid/key at a negedge with the DUT idle.
  task automatic run_stream(input logic [127:0] mk, input int inject_at,
                            input bit chain, input logic [127:0] next_mk);
    model(mk);
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    total++;
    if (keys_ok !== 1'b0) begin
      bad++; $display("FAIL keys_ok_after_accept: got %b exp 0", keys_ok);
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      key_valid = 1'b0;
      obs_rk[i] = rk_out;
      total++;
      if (rk_valid !== 1'b1) begin
        bad++; $display("FAIL rk_valid[%0d]: got %b exp 1", i, rk_valid);
      end
      total++;
      if (rk_idx !== 5'(i)) begin
        bad++; $display("FAIL rk_idx[%0d]: got %0d exp %0d", i, rk_idx, i);
      end
      total++;
      if (rk_out !== exp_rk[i]) begin
        bad++; $display("FAIL rk_out[%0d]: got %h exp %h", i, rk_out, exp_rk[i]);
      end
      total++;
      if (done !== (i == 31)) begin
        bad++; $display("FAIL done[%0d]: got %b exp %b", i, done, i == 31);
      end
      total++;
      if (keys_ok !== (i == 31)) begin
        bad++; $display("FAIL keys_ok[%0d]: got %b exp %b", i, keys_ok, i == 31);
      end
      total++;
      if (key_ready !== (i == 31)) begin
        bad++; $display("FAIL key_ready[%0d]: got %b exp %b", i, key_ready, i == 31);
      end
      if (i + 2 == inject_at) begin
        key_valid = 1'b1;
        key = ~mk;
      end
      if (chain && i == 31) begin
        key_valid = 1'b1;
        key = next_mk;
      end
    end
    if (!chain) begin
      @(negedge clk);
      total++;
      if (rk_valid !== 1'b0 || done !== 1'b0 || keys_ok !== 1'b1) begin
        bad++; $display("FAIL post_stream: got valid=%b done=%b ok=%b exp 0 0 1",
                        rk_valid, done, keys_ok);
      end
    end
  endtask

  task automatic check_reads();
    logic [31:0] e;
    total++;
    if (keys_ok !== 1'b1) begin
      bad++; $display("FAIL reads_keys_ok: got %b exp 1", keys_ok);
    end
    for (int d = 0; d < 2; d++) begin
      for (int idx = 0; idx < 32; idx++) begin
        rd_idx = 5'(idx);
        rd_dec = d[0];
        @(negedge clk);
        e = exp_rk[d == 1 ? 31 - idx : idx];
        total++;
        if (rk_rd !== e) begin
          bad++; $display("FAIL rk_rd dec=%0d idx=%0d: got %h exp %h", d, idx, rk_rd, e);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; key_valid = 1'b0; key = '0; rd_idx = '0; rd_dec = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0 || done !== 1'b0 || keys_ok !== 1'b0) begin
      bad++; $display("FAIL reset_ctl: got rdy=%b valid=%b done=%b ok=%b exp 1 0 0 0",
                      key_ready, rk_valid, done, keys_ok);
    end
    total++;
    if (rk_out !== 32'd0 || rk_idx !== 5'd0 || rk_rd !== 32'd0) begin
      bad++; $display("FAIL reset_data: got rk=%h idx=%0d rd=%h exp 0 0 0", rk_out, rk_idx, rk_rd);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_standard();
    int          idxs [5];
    logic [31:0] vals [5];
    idxs = '{0, 1, 2, 3, 31};
    vals = '{32'hF12186F9, 32'h41662B61, 32'h5A6AB19A, 32'h7BA92077, 32'h9124A012};
    key_valid = 1'b1; key = STD_MK;
    run_stream(STD_MK, -1, 1'b0, '0);
    for (int n = 0; n < 5; n++) begin
      total++;
      if (obs_rk[idxs[n]] !== vals[n]) begin
        bad++; $display("FAIL std_rk%0d: got %h exp %h", idxs[n], obs_rk[idxs[n]], vals[n]);
      end
    end
  endtask

  task automatic test_reverse_read();
    rd_idx = 5'd0; rd_dec = 1'b1;
    @(negedge clk);
    total++;
    if (rk_rd !== 32'h9124A012) begin
      bad++; $display("FAIL rev_read0: got %h exp 9124a012", rk_rd);
    end
    rd_dec = 1'b0;
    @(negedge clk);
    total++;
    if (rk_rd !== 32'hF12186F9) begin
      bad++; $display("FAIL fwd_read0: got %h exp f12186f9", rk_rd);
    end
    check_reads();
  endtask

  task automatic test_busy_reject();
    key_valid = 1'b1; key = STD_MK;
    run_stream(STD_MK, 5, 1'b0, '0);
    check_reads();
  endtask

  task automatic test_back_to_back();
    key_valid = 1'b1; key = STD_MK;
    run_stream(STD_MK, -1, 1'b1, 128'd0);
    run_stream(128'd0, -1, 1'b0, '0);
    check_reads();
  endtask

  task automatic test_reset_mid_run();
    key_valid = 1'b1; key = STD_MK;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0 || keys_ok !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got rdy=%b valid=%b ok=%b done=%b exp 1 0 0 0",
                      key_ready, rk_valid, keys_ok, done);
    end
    total++;
    if (rk_out !== 32'd0 || rk_idx !== 5'd0 || rk_rd !== 32'd0) begin
      bad++; $display("FAIL mid_reset_data: got rk=%h idx=%0d rd=%h exp 0 0 0", rk_out, rk_idx, rk_rd);
    end
    key_valid = 1'b1; key = STD_MK;
    run_stream(STD_MK, -1, 1'b0, '0);
    check_reads();
  endtask

  task automatic test_random();
    logic [127:0] mk;
    for (int it = 0; it < 200; it++) begin
      mk = {$urandom, $urandom, $urandom, $urandom};
      key_valid = 1'b1; key = mk;
      run_stream(mk, -1, 1'b0, '0);
      check_reads();
    end
  endtask

  initial begin
    test_reset();
    test_standard();
    test_reverse_read();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
